pipereg_skid_stage: RTL and testbench

Parametrised successor to the fixed EX/MEM stage register: a generic inter-stage pipeline register with a valid/ready handshake, a one-entry skid buffer, synchronous flush, and bubble tracking. Any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it with its own payload width. Stalls are expressed as back-pressure instead of per-stage wait inputs. Upstream ready is driven from a flop, so no combinational ready path crosses the stage.

---
 rtl/pipereg_skid_stage_pkg.sv | 31 +++
 rtl/pipereg_skid_stage_if.sv | 26 ++
 rtl/pipereg_sat_counter.sv | 29 ++
 rtl/pipereg_skid_stage.sv | 112 +++++++++++
 tb/tb_pipereg_skid_stage.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipereg_skid_stage_pkg.sv
// Shared types for the generic pipeline stage register (package pipes).
// Stage payload structs are passed to the stage as WIDTH = $bits(<struct>).
package pipes;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  localparam int DEFAULT_CNT_W = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } decode_data_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] result;
    logic        wr_en;
  } execute_data_t;

endpackage

// File: rtl/pipereg_skid_stage_if.sv
// Handshake bundle around one stage register: upstream valid/ready/data,
// downstream valid/ready/data, bubble flag and synchronous flush.
interface pipereg_skid_stage_if #(
  parameter int WIDTH = 64
);
  // A transfer happens on a rising edge where valid && ready. valid never
  // depends on ready, and data is held stable while valid && !ready.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_bubble;
  logic             flush;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, out_bubble
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, out_bubble
  );
endinterface

// File: rtl/pipereg_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by reset.
module pipereg_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/pipereg_skid_stage.sv
// Generic inter-stage register with a one-entry skid buffer and registered in_ready.
// Define PIPEREG_PERF_EN to add the saturating stall_cnt / bubble_cnt counters.
module pipereg_skid_stage
  import pipes::*;
#(
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  pipereg_skid_stage_if.slave  bus,
  output stage_state_t         dbg_state
`ifdef PIPEREG_PERF_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
`endif
);
  stage_state_t     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = bus.in_valid && in_ready_q;
  assign out_xfer  = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      // Flush wins over everything; a same-cycle input is discarded.
      state_d = EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = bus.in_data;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            state_d = TWO;
            skid_d  = bus.in_data;
          end else if (in_xfer && out_xfer) begin
            main_d  = bus.in_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
            main_d  = RESET_VALUE;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = RESET_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = RESET_VALUE;
          skid_d  = RESET_VALUE;
        end
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      main_q     <= RESET_VALUE;
      skid_q     <= RESET_VALUE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_valid ? main_q : RESET_VALUE;
  assign bus.out_bubble = !out_valid;
  assign dbg_state      = state_q;

`ifdef PIPEREG_PERF_EN
  pipereg_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid && !bus.out_ready),
    .count (stall_cnt)
  );

  pipereg_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!out_valid),
    .count (bubble_cnt)
  );
`endif
endmodule

// File: tb/tb_pipereg_skid_stage.sv
// Bench for pipereg_skid_stage: directed vector table, hand-written corner
// sequences, then randomized traffic against a 2-deep queue reference.
module tb_pipereg_skid_stage;
  import pipes::*;

  localparam int             W   = 8;
  localparam int             CW  = 3;
  localparam logic [W-1:0]   RV  = 8'hEE;

  logic clk = 1'b0;
  logic reset;
  stage_state_t dbg_state;
`ifdef PIPEREG_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipereg_skid_stage_if #(.WIDTH(W)) bus ();

  pipereg_skid_stage #(
    .WIDTH       (W),
    .RESET_VALUE (RV),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state  (dbg_state)
`ifdef PIPEREG_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  typedef struct packed {
    logic         iv;
    logic [W-1:0] d;
    logic         o_r;
    logic         fl;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic         e_ir;
    stage_state_t e_st;
  } vec_t;

  vec_t vecs[23];

  // scoreboard: contents of the stage, oldest first
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic o_r, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = o_r;
    bus.flush     = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic vec_t mk(logic iv, logic [W-1:0] d, logic o_r, logic fl,
                              logic e_ov, logic [W-1:0] e_od, logic e_ir, stage_state_t e_st);
    vec_t v;
    v.iv = iv; v.d = d; v.o_r = o_r; v.fl = fl;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_st = e_st;
    return v;
  endfunction

  initial begin
    logic         pend_valid;
    logic [W-1:0] pend_data;
    logic         model_ir;
    logic         o_r, fl, in_x, out_x;

    // streaming
    vecs[0]  = mk(1, 8'd1, 1, 0,  0, RV,    1, EMPTY);
    vecs[1]  = mk(1, 8'd2, 1, 0,  1, 8'd1,  1, ONE);
    vecs[2]  = mk(1, 8'd3, 1, 0,  1, 8'd2,  1, ONE);
    vecs[3]  = mk(1, 8'd4, 1, 0,  1, 8'd3,  1, ONE);
    vecs[4]  = mk(0, 8'd0, 1, 0,  1, 8'd4,  1, ONE);
    vecs[5]  = mk(0, 8'd0, 0, 0,  0, RV,    1, EMPTY);
    // back-pressure: 2 lands in skid, 3 waits upstream
    vecs[6]  = mk(1, 8'd1, 0, 0,  0, RV,    1, EMPTY);
    vecs[7]  = mk(1, 8'd2, 0, 0,  1, 8'd1,  1, ONE);
    vecs[8]  = mk(1, 8'd3, 0, 0,  1, 8'd1,  0, TWO);
    vecs[9]  = mk(1, 8'd3, 0, 0,  1, 8'd1,  0, TWO);
    vecs[10] = mk(1, 8'd3, 1, 0,  1, 8'd1,  0, TWO);
    vecs[11] = mk(1, 8'd3, 1, 0,  1, 8'd2,  1, ONE);
    vecs[12] = mk(0, 8'd0, 1, 0,  1, 8'd3,  1, ONE);
    vecs[13] = mk(0, 8'd0, 0, 0,  0, RV,    1, EMPTY);
    // simultaneous in/out in ONE
    vecs[14] = mk(1, 8'd5, 0, 0,  0, RV,    1, EMPTY);
    vecs[15] = mk(1, 8'd6, 1, 0,  1, 8'd5,  1, ONE);
    vecs[16] = mk(0, 8'd0, 0, 0,  1, 8'd6,  1, ONE);
    // flush in TWO with 9 offered
    vecs[17] = mk(1, 8'd7, 0, 0,  1, 8'd6,  1, ONE);
    vecs[18] = mk(1, 8'd9, 0, 1,  1, 8'd6,  0, TWO);
    vecs[19] = mk(0, 8'd0, 0, 0,  0, RV,    1, EMPTY);
    // flush in ONE drops an accepted-looking input
    vecs[20] = mk(1, 8'd8, 0, 0,  0, RV,    1, EMPTY);
    vecs[21] = mk(1, 8'd9, 1, 1,  1, 8'd8,  1, ONE);
    vecs[22] = mk(0, 8'd0, 1, 0,  0, RV,    1, EMPTY);

    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_out_data",   32'(bus.out_data),   32'(RV));
    check("rst_in_ready",   32'(bus.in_ready),   32'd1);
    check("rst_out_bubble", 32'(bus.out_bubble), 32'd1);
    check("rst_state",      32'(dbg_state),      32'(EMPTY));
    reset = 1'b1;
    next_cycle();

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].o_r, vecs[i].fl);
      @(negedge clk);
      check($sformatf("vec%0d_out_valid", i),  32'(bus.out_valid),  32'(vecs[i].e_ov));
      check($sformatf("vec%0d_out_data", i),   32'(bus.out_data),   32'(vecs[i].e_od));
      check($sformatf("vec%0d_in_ready", i),   32'(bus.in_ready),   32'(vecs[i].e_ir));
      check($sformatf("vec%0d_out_bubble", i), 32'(bus.out_bubble), 32'(!vecs[i].e_ov));
      check($sformatf("vec%0d_state", i),      32'(dbg_state),      32'(vecs[i].e_st));
      next_cycle();
    end

    // asynchronous reset in the middle of a held transfer
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_out_data",  32'(bus.out_data),  32'(RV));
    check("async_rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_still_empty", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_first_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_first_data",  32'(bus.out_data),  32'hA5);

`ifdef PIPEREG_PERF_EN
    reset_pulse();
    check("perf_rst_stall",  32'(stall_cnt),  32'd0);
    check("perf_rst_bubble", 32'(bubble_cnt), 32'd0);
    drive(1'b1, 8'd1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) next_cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) next_cycle();
    check("perf_stall_3",  32'(stall_cnt),  32'd3);
    check("perf_bubble_4", 32'(bubble_cnt), 32'd4);
    drive(1'b0, '0, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("perf_flush_keeps_stall",  32'(stall_cnt),  32'd3);
    check("perf_flush_keeps_bubble", 32'(bubble_cnt), 32'd5);
    repeat (5) next_cycle();
    check("perf_bubble_saturate", 32'(bubble_cnt), 32'((1 << CW) - 1));
    check("perf_stall_hold",      32'(stall_cnt),  32'd3);
`endif

    // randomized traffic against the queue model
    reset_pulse();
    exp_q.delete();
    model_ir   = 1'b1;
    pend_valid = 1'b0;
    pend_data  = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pend_valid && ($urandom_range(0, 99) < 60)) begin
        pend_valid = 1'b1;
        pend_data  = W'($urandom_range(0, 255));
      end
      o_r = ($urandom_range(0, 99) < 65);
      fl  = ($urandom_range(0, 39) == 0);
      drive(pend_valid, pend_data, o_r, fl);
      @(negedge clk);
      check("rnd_out_valid",  32'(bus.out_valid),  32'(exp_q.size() > 0));
      check("rnd_out_data",   32'(bus.out_data),   32'((exp_q.size() > 0) ? exp_q[0] : RV));
      check("rnd_in_ready",   32'(bus.in_ready),   32'(model_ir));
      check("rnd_out_bubble", 32'(bus.out_bubble), 32'(exp_q.size() == 0));
      in_x  = pend_valid && model_ir;
      out_x = (exp_q.size() > 0) && o_r;
      if (fl) begin
        exp_q.delete();
      end else begin
        if (out_x) void'(exp_q.pop_front());
        if (in_x)  exp_q.push_back(pend_data);
      end
      model_ir = (exp_q.size() < 2);
      if (in_x) pend_valid = 1'b0;
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
